fm_ram_arbiter: RTL and testbench
=================================

FM_RAM_ARBITER -- requirements
Module: fm_ram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, 4, host write buffer entries (power of two, 2..16).
REQ-002 Parameter STARVE_LIMIT, 8, consecutive playback grants tolerated while writes are pending.
REQ-003 Clock  in  1  single clock; all logic on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Host_Addr_IN  in  13  host word address.
REQ-006 Host_Data_IN  in  16  host write data.
REQ-007 Host_Wr_IN  in  1  host write strobe, one cycle per write.
REQ-008 Host_Busy_OUT  out  1  write buffer full.
REQ-009 Ovf_OUT  out  1  sticky flag: a write was dropped.
REQ-010 Play_Req_IN  in  1  playback read request, sampled every edge.
REQ-011 Play_Addr_IN  in  12  playback read address.
REQ-012 Play_Ack_OUT  out  1  the request sampled at the previous edge was granted.
REQ-013 Play_Data_OUT  out  16  read data.
REQ-014 Play_Valid_OUT  out  1  Play_Data_OUT valid.
REQ-015 Ram_Addr_OUT  out  12  registered single-port RAM address.
REQ-016 Ram_Wdata_OUT  out  16  registered RAM write data.
REQ-017 Ram_We_OUT  out  1  registered RAM write enable.
REQ-018 Ram_Rdata_IN  in  16  synchronous RAM read data, one cycle after address.

Function
REQ-019 Window: a host write is in window when Host_Addr_IN[12]=1 (0x1000-0x1FFF); out-of-window strobes are ignored; RAM address = Host_Addr_IN[11:0].
REQ-020 An in-window strobe with buffer not full (or full with a same-edge pop) pushes {addr,data}; otherwise it is dropped and Ovf_OUT sets.
REQ-021 Host_Busy_OUT = count==FIFO_DEPTH, registered.
REQ-022 Owner FSM states IDLE, PLAY, WRITE; next state evaluated each edge.
REQ-023 PLAY when Play_Req_IN=1 and no starvation override; else WRITE when buffer non-empty; else IDLE.
REQ-024 Entering WRITE pops one entry and registers Ram_We_OUT=1 with its addr/data; all other states register Ram_We_OUT=0.
REQ-025 Entering PLAY registers Ram_Addr_OUT=Play_Addr_IN; Play_Ack_OUT=1 while state=PLAY.
REQ-026 Play_Valid_OUT=1 with Play_Data_OUT=Ram_Rdata_IN (registered) exactly one cycle after each Play_Ack_OUT cycle: total latency request-edge to valid = 2 cycles.
REQ-027 Back-to-back Play_Req_IN yields one read per cycle; writes wait.
REQ-028 In IDLE, Ram_Addr_OUT holds its last value.

Reset
REQ-029 Reset: state IDLE, buffer emptied (pending writes discarded), Ram_We_OUT=0, Ram_Addr_OUT=0, Ram_Wdata_OUT=0, Play_Ack_OUT=0, Play_Valid_OUT=0, Play_Data_OUT=0, Host_Busy_OUT=0, Ovf_OUT=0, starvation counter 0.
REQ-030 Reset during an in-flight read suppresses its Play_Valid_OUT.

Configuration
REQ-031 With FM_RAM_STARVE_GUARD_EN defined: a counter counts consecutive PLAY grants while the buffer is non-empty; when it reaches STARVE_LIMIT, the next grant is WRITE regardless of Play_Req_IN and the counter clears; the counter also clears on any non-PLAY state.
REQ-032 Without FM_RAM_STARVE_GUARD_EN: strict playback priority, no counter logic; STARVE_LIMIT unused.

Structure
REQ-033 Package fm_ram_pkg holds the owner-state enum, address/data widths (12/16) and window constant 13'h1000.
REQ-034 The write buffer is sub-module fm_wr_fifo (synchronous, registered count, push/pop/full/empty).

Verification
REQ-035 Host writes 0x1005=0xABCD, no playback -> Ram_We_OUT=1, Ram_Addr_OUT=0x005, Ram_Wdata_OUT=0xABCD two edges after the strobe.
REQ-036 Strobe at 0x0005 -> no RAM write, Ovf_OUT stays 0.
REQ-037 Play_Req_IN held 3 cycles, addresses 0x010-0x012 -> Play_Valid_OUT for 3 consecutive cycles, 2-cycle latency, data matches RAM model.
REQ-038 5 writes in 5 cycles with Play_Req_IN held high (guard off) -> Host_Busy_OUT=1 after the 4th, 5th dropped, Ovf_OUT=1, no RAM writes until Play_Req_IN drops.
REQ-039 Guard on, 1 pending write, Play_Req_IN held high -> the write is granted on cycle 9 and Play_Ack_OUT is low for that single cycle.
REQ-040 Reset asserted the cycle after a PLAY grant -> no Play_Valid_OUT, buffer empty, all outputs at reset values.

Source files
------------

// File: rtl/fm_ram_pkg.sv
// Shared types and constants for the FM sample-RAM arbiter: owner states,
// RAM word geometry and the host write window.
package fm_ram_pkg;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int HOST_ADDR_W = 13;
  localparam logic [HOST_ADDR_W-1:0] WINDOW_BASE = 13'h1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_WRITE = 2'd2
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  function automatic logic in_window(input logic [HOST_ADDR_W-1:0] a);
    return (a & WINDOW_BASE) == WINDOW_BASE;
  endfunction
endpackage

// File: rtl/fm_wr_fifo.sv
// Host write buffer: synchronous FIFO with registered count and flags.
// A push while full is accepted only when a pop happens on the same edge.
module fm_wr_fifo
  import fm_ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    Clock,
  input  logic    Reset,
  input  logic    i_push,
  input  logic    i_pop,
  input  wr_ent_t i_data,
  output wr_ent_t o_data,
  output logic    o_full,
  output logic    o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_ent_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_full, r_empty, w_push, w_pop;

  assign w_pop  = i_pop && !r_empty;
  assign w_push = i_push && (!r_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/fm_ram_arbiter.sv
// Single-port sample RAM arbiter: playback reads win, buffered host writes fill gaps.
// Define FM_RAM_STARVE_GUARD_EN to force a write after STARVE_LIMIT back-to-back reads.
module fm_ram_arbiter
  import fm_ram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [HOST_ADDR_W-1:0] Host_Addr_IN,
  input  logic [DATA_W-1:0]      Host_Data_IN,
  input  logic                   Host_Wr_IN,
  output logic                   Host_Busy_OUT,
  output logic                   Ovf_OUT,
  input  logic                   Play_Req_IN,
  input  logic [ADDR_W-1:0]      Play_Addr_IN,
  output logic                   Play_Ack_OUT,
  output logic [DATA_W-1:0]      Play_Data_OUT,
  output logic                   Play_Valid_OUT,
  output logic [ADDR_W-1:0]      Ram_Addr_OUT,
  output logic [DATA_W-1:0]      Ram_Wdata_OUT,
  output logic                   Ram_We_OUT,
  input  logic [DATA_W-1:0]      Ram_Rdata_IN
);
  owner_e            r_state, w_state_nxt;
  wr_ent_t           w_fifo_din, w_fifo_dout;
  logic              w_fifo_full, w_fifo_empty;
  logic              w_in_win, w_drop, w_starve, w_ld_write, w_ld_play;
  logic              r_ram_we, r_vld_p1, r_vld_p2, r_ovf;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, r_data_p2;

  assign w_in_win   = Host_Wr_IN && in_window(Host_Addr_IN);
  assign w_fifo_din = '{addr: Host_Addr_IN[ADDR_W-1:0], data: Host_Data_IN};
  assign w_drop     = w_in_win && w_fifo_full && !w_ld_write;

  fm_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_push  (w_in_win),
    .i_pop   (w_ld_write),
    .i_data  (w_fifo_din),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef FM_RAM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve_cnt;

  assign w_starve = !w_fifo_empty && (r_starve_cnt >= SW'(STARVE_LIMIT));

  // Only reads granted while a write is waiting count toward starvation.
  always_ff @(posedge Clock) begin
    if (Reset)                                           r_starve_cnt <= '0;
    else if (w_state_nxt == ST_PLAY && !w_fifo_empty)    r_starve_cnt <= r_starve_cnt + SW'(1);
    else                                                 r_starve_cnt <= '0;
  end
`else
  assign w_starve = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (Play_Req_IN && !w_starve) w_state_nxt = ST_PLAY;
    else if (!w_fifo_empty)       w_state_nxt = ST_WRITE;
  end

  always_comb begin
    w_ld_write = (w_state_nxt == ST_WRITE);
    w_ld_play  = (w_state_nxt == ST_PLAY);
  end

  // p0: RAM command; p1: RAM access in flight; p2: read data returned
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_data_p2   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_ram_we <= w_ld_write;
      if (w_ld_write) begin
        r_ram_addr  <= w_fifo_dout.addr;
        r_ram_wdata <= w_fifo_dout.data;
      end else if (w_ld_play) begin
        r_ram_addr <= Play_Addr_IN;
      end
      r_vld_p1 <= (r_state == ST_PLAY);
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_data_p2 <= Ram_Rdata_IN;
      if (w_drop)   r_ovf     <= 1'b1;
    end
  end

  assign Host_Busy_OUT  = w_fifo_full;
  assign Ovf_OUT        = r_ovf;
  assign Play_Ack_OUT   = (r_state == ST_PLAY);
  assign Play_Valid_OUT = r_vld_p2;
  assign Play_Data_OUT  = r_data_p2;
  assign Ram_Addr_OUT   = r_ram_addr;
  assign Ram_Wdata_OUT  = r_ram_wdata;
  assign Ram_We_OUT     = r_ram_we;
endmodule

// File: tb/tb_fm_ram_arbiter.sv
// Bench for fm_ram_arbiter: directed vector table, hand-written corner sequences,
// and random traffic against a queue-based reference model with a shadow RAM.
module tb_fm_ram_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [12:0] Host_Addr_IN = '0;
  logic [15:0] Host_Data_IN = '0;
  logic        Host_Wr_IN = 1'b0;
  logic        Host_Busy_OUT, Ovf_OUT;
  logic        Play_Req_IN = 1'b0;
  logic [11:0] Play_Addr_IN = '0;
  logic        Play_Ack_OUT, Play_Valid_OUT, Ram_We_OUT;
  logic [15:0] Play_Data_OUT, Ram_Wdata_OUT;
  logic [11:0] Ram_Addr_OUT;
  logic [15:0] Ram_Rdata_IN;

  fm_ram_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .Host_Addr_IN(Host_Addr_IN), .Host_Data_IN(Host_Data_IN), .Host_Wr_IN(Host_Wr_IN),
    .Host_Busy_OUT(Host_Busy_OUT), .Ovf_OUT(Ovf_OUT),
    .Play_Req_IN(Play_Req_IN), .Play_Addr_IN(Play_Addr_IN), .Play_Ack_OUT(Play_Ack_OUT),
    .Play_Data_OUT(Play_Data_OUT), .Play_Valid_OUT(Play_Valid_OUT),
    .Ram_Addr_OUT(Ram_Addr_OUT), .Ram_Wdata_OUT(Ram_Wdata_OUT), .Ram_We_OUT(Ram_We_OUT),
    .Ram_Rdata_IN(Ram_Rdata_IN)
  );

  always #5 Clock = ~Clock;

  // Synchronous single-port RAM attached to the arbiter
  logic [15:0] ram [4096];
  always @(posedge Clock) begin
    if (Ram_We_OUT) ram[Ram_Addr_OUT] <= Ram_Wdata_OUT;
    Ram_Rdata_IN <= ram[Ram_Addr_OUT];
  end

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 37 + 11) ^ 16'h5A00);
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes in a queue, shadow memory updated at grant time
  typedef struct { logic [11:0] a; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  logic [15:0] mram [4096];
  int          m_cnt = 0;
  logic        m_busy = 0, m_ovf = 0, m_ack = 0, m_v1 = 0, m_valid = 0, m_we = 0;
  logic [15:0] m_dack = 0, m_d1 = 0, m_pdata = 0, m_wdata = 0;
  logic [11:0] m_addr = 0;

  task automatic model_edge();
    bit   pending, starve, grant_play, grant_write;
    ent_t e;
    if (Reset) begin
      mq.delete();
      m_cnt = 0; m_busy = 0; m_ovf = 0; m_ack = 0; m_v1 = 0; m_valid = 0;
      m_we = 0; m_pdata = 0; m_wdata = 0; m_addr = 0;
      return;
    end
    pending = (mq.size() > 0);
    starve  = 0;
`ifdef FM_RAM_STARVE_GUARD_EN
    starve = pending && (m_cnt >= LIMIT);
`endif
    if (m_v1) m_pdata = m_d1;
    m_valid = m_v1;
    m_v1    = m_ack;
    m_d1    = m_dack;
    grant_play  = Play_Req_IN && !starve;
    grant_write = !grant_play && pending;
    m_ack = grant_play;
    m_we  = grant_write;
    if (grant_write) begin
      e = mq.pop_front();
      m_addr  = e.a;
      m_wdata = e.d;
      mram[e.a] = e.d;
    end else if (grant_play) begin
      m_addr = Play_Addr_IN;
      m_dack = mram[Play_Addr_IN];
    end
    if (Host_Wr_IN && Host_Addr_IN >= 13'h1000) begin
      if (mq.size() < DEPTH) mq.push_back('{a: Host_Addr_IN[11:0], d: Host_Data_IN});
      else                   m_ovf = 1;
    end
    m_busy = (mq.size() == DEPTH);
    m_cnt  = (grant_play && pending) ? m_cnt + 1 : 0;
  endtask

  task automatic check_model();
    check("busy",  Host_Busy_OUT,  m_busy);
    check("ovf",   Ovf_OUT,        m_ovf);
    check("ack",   Play_Ack_OUT,   m_ack);
    check("valid", Play_Valid_OUT, m_valid);
    check("pdata", Play_Data_OUT,  m_pdata);
    check("we",    Ram_We_OUT,     m_we);
    check("raddr", Ram_Addr_OUT,   m_addr);
    check("wdata", Ram_Wdata_OUT,  m_wdata);
  endtask

  task automatic step(input logic wr, input logic [12:0] ha, input logic [15:0] hd,
                      input logic pr, input logic [11:0] pa, input logic rst);
    Host_Wr_IN = wr; Host_Addr_IN = ha; Host_Data_IN = hd;
    Play_Req_IN = pr; Play_Addr_IN = pa; Reset = rst;
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check_model();
  endtask

  task automatic idle(input logic pr, input logic [11:0] pa);
    step(1'b0, 13'h0, 16'h0, pr, pa, 1'b0);
  endtask

  typedef struct {
    logic        wr; logic [12:0] ha; logic [15:0] hd; logic pr; logic [11:0] pa;
    logic        e_we; logic [11:0] e_addr; logic [15:0] e_wdata;
    logic        e_ack; logic e_valid; logic [15:0] e_pdata; logic e_ovf;
  } vec_t;
  vec_t vt [12];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = init_word(i);
      mram[i] = init_word(i);
    end
    vt[0]  = '{1, 13'h1005, 16'hABCD, 0, 12'h000, 0, 12'h000, 16'h0000, 0, 0, 16'h0, 0};
    vt[1]  = '{0, 13'h0000, 16'h0000, 0, 12'h000, 1, 12'h005, 16'hABCD, 0, 0, 16'h0, 0};
    vt[2]  = '{1, 13'h0005, 16'h1111, 0, 12'h000, 0, 12'h005, 16'hABCD, 0, 0, 16'h0, 0};
    vt[3]  = '{0, 13'h0000, 16'h0000, 0, 12'h000, 0, 12'h005, 16'hABCD, 0, 0, 16'h0, 0};
    vt[4]  = '{0, 13'h0000, 16'h0000, 1, 12'h010, 0, 12'h010, 16'hABCD, 1, 0, 16'h0, 0};
    vt[5]  = '{0, 13'h0000, 16'h0000, 1, 12'h011, 0, 12'h011, 16'hABCD, 1, 0, 16'h0, 0};
    vt[6]  = '{0, 13'h0000, 16'h0000, 1, 12'h012, 0, 12'h012, 16'hABCD, 1, 1, init_word(16), 0};
    vt[7]  = '{0, 13'h0000, 16'h0000, 0, 12'h000, 0, 12'h012, 16'hABCD, 0, 1, init_word(17), 0};
    vt[8]  = '{0, 13'h0000, 16'h0000, 0, 12'h000, 0, 12'h012, 16'hABCD, 0, 1, init_word(18), 0};
    vt[9]  = '{0, 13'h0000, 16'h0000, 1, 12'h005, 0, 12'h005, 16'hABCD, 1, 0, 16'h0, 0};
    vt[10] = '{0, 13'h0000, 16'h0000, 0, 12'h000, 0, 12'h005, 16'hABCD, 0, 0, 16'h0, 0};
    vt[11] = '{0, 13'h0000, 16'h0000, 0, 12'h000, 0, 12'h005, 16'hABCD, 0, 1, 16'hABCD, 0};

    // Reset state
    step(0, 13'h0, 16'h0, 0, 12'h0, 1);
    step(0, 13'h0, 16'h0, 0, 12'h0, 1);

    // Directed table: window write, ignored write, 3-read burst, read-after-write
    for (int i = 0; i < 12; i++) begin
      step(vt[i].wr, vt[i].ha, vt[i].hd, vt[i].pr, vt[i].pa, 1'b0);
      check($sformatf("tbl%0d_we", i),    Ram_We_OUT,     vt[i].e_we);
      check($sformatf("tbl%0d_addr", i),  Ram_Addr_OUT,   vt[i].e_addr);
      check($sformatf("tbl%0d_wdata", i), Ram_Wdata_OUT,  vt[i].e_wdata);
      check($sformatf("tbl%0d_ack", i),   Play_Ack_OUT,   vt[i].e_ack);
      check($sformatf("tbl%0d_valid", i), Play_Valid_OUT, vt[i].e_valid);
      check($sformatf("tbl%0d_ovf", i),   Ovf_OUT,        vt[i].e_ovf);
      if (vt[i].e_valid) check($sformatf("tbl%0d_pdata", i), Play_Data_OUT, vt[i].e_pdata);
    end

    // Buffer overflow while playback holds the RAM
    step(0, 13'h0, 16'h0, 0, 12'h0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 13'(13'h1000 + i), 16'(16'hC000 + i), 1, 12'(12'h100 + i), 0);
      check("ovfseq_we", Ram_We_OUT, 1'b0);
      check("ovfseq_busy", Host_Busy_OUT, i >= 3);
      check("ovfseq_ovf", Ovf_OUT, i == 4);
    end
    idle(1, 12'h200);
    check("ovfseq_hold_we", Ram_We_OUT, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(0, 12'h0);
      check("drain_we", Ram_We_OUT, 1'b1);
      check("drain_addr", Ram_Addr_OUT, 12'(i));
      check("drain_wdata", Ram_Wdata_OUT, 16'(16'hC000 + i));
      check("drain_busy", Host_Busy_OUT, 1'b0);
    end
    idle(0, 12'h0);
    check("drain_done_we", Ram_We_OUT, 1'b0);
    check("drain_ovf_sticky", Ovf_OUT, 1'b1);

`ifdef FM_RAM_STARVE_GUARD_EN
    // Starvation guard: one write waits behind continuous playback
    step(0, 13'h0, 16'h0, 0, 12'h0, 1);
    step(1, 13'h1ABC, 16'h1234, 1, 12'h020, 0);
    check("starve_first_ack", Play_Ack_OUT, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      idle(1, 12'(12'h020 + k));
      check($sformatf("starve_ack_c%0d", k), Play_Ack_OUT, k != 9);
      check($sformatf("starve_we_c%0d", k),  Ram_We_OUT,   k == 9);
    end
`endif

    // Reset right after a playback grant
    step(0, 13'h0, 16'h0, 0, 12'h0, 1);
    step(1, 13'h1040, 16'h5555, 1, 12'h030, 0);
    check("rst_pre_ack", Play_Ack_OUT, 1'b1);
    step(0, 13'h0, 16'h0, 1, 12'h031, 1);
    check("rst_ack", Play_Ack_OUT, 1'b0);
    check("rst_valid", Play_Valid_OUT, 1'b0);
    check("rst_we", Ram_We_OUT, 1'b0);
    check("rst_addr", Ram_Addr_OUT, 12'h0);
    check("rst_wdata", Ram_Wdata_OUT, 16'h0);
    check("rst_pdata", Play_Data_OUT, 16'h0);
    check("rst_busy", Host_Busy_OUT, 1'b0);
    check("rst_ovf", Ovf_OUT, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(0, 12'h0);
      check("rst_after_valid", Play_Valid_OUT, 1'b0);
      check("rst_after_we", Ram_We_OUT, 1'b0);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      logic        wr, pr, rst;
      logic [12:0] ha;
      wr  = ($urandom_range(0, 2) == 0);
      ha  = {($urandom_range(0, 7) != 0), 7'h0, 5'($urandom_range(0, 31))};
      pr  = ((n / 16) % 2 == 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(wr, ha, 16'($urandom), pr, 12'($urandom_range(0, 31)), rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
